product_accum: RTL and testbench

PRODUCT_ACCUM -- requirements
Module: product_accum

---
 rtl/sc_arch_pkg.sv | 14 +
 rtl/acc_adder.sv | 28 ++
 rtl/product_accum.sv | 92 +++++++++
 tb/tb_product_accum.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/sc_arch_pkg.sv
// Shared types and default widths for the product accumulator slice.
package sc_arch_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_ACC_WIDTH  = 24;
    localparam int DEF_CNT_WIDTH  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/acc_adder.sv
// Accumulator adder: zero-extends a term, adds it and reports carry-out.
// PRODUCT_ACCUM_SATURATE_EN clamps the sum to all-ones on carry instead of wrapping.
module acc_adder
    import sc_arch_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH
)(
    input  logic [ACC_WIDTH-1:0]  acc,
    input  logic [DATA_WIDTH-1:0] term,
    output logic [ACC_WIDTH-1:0]  sum,
    output logic                  carry
);

    logic [ACC_WIDTH:0] wide;

    always_comb begin
        wide  = {1'b0, acc} + {{(ACC_WIDTH + 1 - DATA_WIDTH){1'b0}}, term};
        carry = wide[ACC_WIDTH];
`ifdef PRODUCT_ACCUM_SATURATE_EN
        // Once clamped, any further nonzero term carries again, so acc stays pinned.
        sum = carry ? {ACC_WIDTH{1'b1}} : wide[ACC_WIDTH-1:0];
`else
        sum = wide[ACC_WIDTH-1:0];
`endif
    end

endmodule

// File: rtl/product_accum.sv
// Dot-product accumulator: sums product terms until last, then holds the result for a handshake.
// Optional build macro PRODUCT_ACCUM_SATURATE_EN selects a clamping accumulator.
module product_accum
    import sc_arch_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
)(
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] io_inputs_0,
    input  logic                  io_in_valid,
    input  logic                  io_in_last,
    output logic                  io_in_ready,
    output logic [ACC_WIDTH-1:0]  io_outs_0,
    output logic [CNT_WIDTH-1:0]  io_out_count,
    output logic                  io_out_ovf,
    output logic                  io_out_valid,
    input  logic                  io_out_ready
);

    state_t                 state;
    state_t                 state_next;
    logic [ACC_WIDTH-1:0]   acc;
    logic [ACC_WIDTH-1:0]   acc_sum;
    logic [CNT_WIDTH-1:0]   cnt;
    logic                   ovf;
    logic                   carry;
    logic                   accept;
    logic                   drain;
    logic                   cnt_full;

    assign accept   = io_in_valid && io_in_ready;
    assign drain    = io_out_valid && io_out_ready;
    assign cnt_full = (cnt == {CNT_WIDTH{1'b1}});

    acc_adder #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
    ) u_adder (
        .acc   (acc),
        .term  (io_inputs_0),
        .sum   (acc_sum),
        .carry (carry)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = io_in_last ? HOLD : ACCUM;
            ACCUM:   if (accept && io_in_last) state_next = HOLD;
            HOLD:    if (io_out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Handshake outputs decode only the registered state, so io_out_ready never reaches io_in_ready.
    always_comb begin
        io_in_ready  = (state == IDLE) || (state == ACCUM);
        io_out_valid = (state == HOLD);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            acc <= '0;
            cnt <= '0;
            ovf <= 1'b0;
        end else if (drain) begin
            acc <= '0;
            cnt <= '0;
            ovf <= 1'b0;
        end else if (accept) begin
            acc <= acc_sum;
            cnt <= cnt_full ? cnt : cnt + CNT_WIDTH'(1);
            ovf <= ovf | carry | cnt_full;
        end
    end

    assign io_outs_0    = acc;
    assign io_out_count = cnt;
    assign io_out_ovf   = ovf;

endmodule

// File: tb/tb_product_accum.sv
// Self-checking bench for product_accum: directed vector table, corner sequences, randomized vectors.
// Expected results follow PRODUCT_ACCUM_SATURATE_EN when it is defined for the build.
module tb_product_accum;

    localparam longint ACC_MAX = 64'h0000_0000_00FF_FFFF;

    logic        clock;
    logic        reset_n;
    logic [15:0] io_inputs_0;
    logic        io_in_valid;
    logic        io_in_last;
    logic        io_in_ready;
    logic [23:0] io_outs_0;
    logic [7:0]  io_out_count;
    logic        io_out_ovf;
    logic        io_out_valid;
    logic        io_out_ready;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int               n;
        logic [3:0][15:0] terms;
        logic [23:0]      exp_sum;
        logic [7:0]       exp_cnt;
        logic             exp_ovf;
    } vec_t;

    vec_t vecs [5];

    product_accum dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .io_inputs_0  (io_inputs_0),
        .io_in_valid  (io_in_valid),
        .io_in_last   (io_in_last),
        .io_in_ready  (io_in_ready),
        .io_outs_0    (io_outs_0),
        .io_out_count (io_out_count),
        .io_out_ovf   (io_out_ovf),
        .io_out_valid (io_out_valid),
        .io_out_ready (io_out_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Reference: result of a whole vector from its arithmetic sum and term count.
    function automatic void model_vec(input longint sum, input int n,
                                      output logic [23:0] r, output logic [7:0] c, output logic o);
        o = (sum > ACC_MAX) || (n > 255);
        c = (n > 255) ? 8'd255 : 8'(n);
`ifdef PRODUCT_ACCUM_SATURATE_EN
        r = (sum > ACC_MAX) ? 24'hFFFFFF : 24'(sum);
`else
        r = 24'(sum);
`endif
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_stimulus(input logic [15:0] d, input logic l);
        int waited = 0;
        io_inputs_0 = d;
        io_in_valid = 1'b1;
        io_in_last  = l;
        while (!io_in_ready && waited < 100) begin
            tick();
            waited++;
        end
        if (waited >= 100) check_output("send_timeout", 32'(io_in_ready), 32'd1);
        tick();
        io_in_valid = 1'b0;
        io_in_last  = 1'b0;
    endtask

    task automatic collect_result(input string name, input logic [23:0] r, input logic [7:0] c,
                                  input logic o, input int stall);
        int waited = 0;
        while (!io_out_valid && waited < 50) begin
            tick();
            waited++;
        end
        check_output({name, "_valid"}, 32'(io_out_valid), 32'd1);
        repeat (stall) tick();
        check_output({name, "_sum"}, 32'(io_outs_0), 32'(r));
        check_output({name, "_count"}, 32'(io_out_count), 32'(c));
        check_output({name, "_ovf"}, 32'(io_out_ovf), 32'(o));
        check_output({name, "_in_ready_hold"}, 32'(io_in_ready), 32'd0);
        io_out_ready = 1'b1;
        tick();
        io_out_ready = 1'b0;
        check_output({name, "_valid_after"}, 32'(io_out_valid), 32'd0);
        check_output({name, "_in_ready_after"}, 32'(io_in_ready), 32'd1);
    endtask

    initial begin
        logic [23:0]   r;
        logic [7:0]    c;
        logic          o;
        longint        sum;
        int            n;
        logic [15:0]   t;

        vecs[0] = '{n: 3, terms: {16'd0, 16'd300, 16'd200, 16'd100},
                    exp_sum: 24'd600, exp_cnt: 8'd3, exp_ovf: 1'b0};
        vecs[1] = '{n: 1, terms: {16'd0, 16'd0, 16'd0, 16'hFFFF},
                    exp_sum: 24'h00FFFF, exp_cnt: 8'd1, exp_ovf: 1'b0};
        vecs[2] = '{n: 2, terms: {16'd0, 16'd0, 16'd8, 16'd7},
                    exp_sum: 24'd15, exp_cnt: 8'd2, exp_ovf: 1'b0};
        vecs[3] = '{n: 4, terms: {16'd0, 16'd0, 16'd0, 16'd0},
                    exp_sum: 24'd0, exp_cnt: 8'd4, exp_ovf: 1'b0};
        vecs[4] = '{n: 4, terms: {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF},
                    exp_sum: 24'h03FFFC, exp_cnt: 8'd4, exp_ovf: 1'b0};

        reset_n      = 1'b0;
        io_inputs_0  = '0;
        io_in_valid  = 1'b0;
        io_in_last   = 1'b0;
        io_out_ready = 1'b0;
        #23;
        check_output("reset_out_valid", 32'(io_out_valid), 32'd0);
        check_output("reset_in_ready", 32'(io_in_ready), 32'd1);
        check_output("reset_sum", 32'(io_outs_0), 32'd0);
        check_output("reset_count", 32'(io_out_count), 32'd0);
        check_output("reset_ovf", 32'(io_out_ovf), 32'd0);
        reset_n = 1'b1;
        tick();

        for (int i = 0; i < 5; i++) begin
            for (int j = 0; j < vecs[i].n; j++)
                apply_stimulus(vecs[i].terms[j], j == vecs[i].n - 1);
            check_output($sformatf("vec%0d_latency", i), 32'(io_out_valid), 32'd1);
            collect_result($sformatf("vec%0d", i), vecs[i].exp_sum, vecs[i].exp_cnt, vecs[i].exp_ovf, 0);
        end

        // 257 full-scale terms: accumulator overflows and the counter saturates.
        for (int k = 0; k < 257; k++) apply_stimulus(16'hFFFF, k == 256);
        model_vec(longint'(257) * 65535, 257, r, c, o);
        collect_result("ovf257", r, c, o, 0);
        apply_stimulus(16'd3, 1'b1);
        collect_result("after_ovf", 24'd3, 8'd1, 1'b0, 0);

        // Stall in HOLD while junk terms are offered.
        apply_stimulus(16'd5, 1'b0);
        apply_stimulus(16'd6, 1'b1);
        io_inputs_0 = 16'h1234;
        io_in_valid = 1'b1;
        io_in_last  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check_output("stall_sum", 32'(io_outs_0), 32'd11);
            check_output("stall_count", 32'(io_out_count), 32'd2);
            check_output("stall_in_ready", 32'(io_in_ready), 32'd0);
            check_output("stall_valid", 32'(io_out_valid), 32'd1);
        end
        io_in_valid = 1'b0;
        io_in_last  = 1'b0;
        collect_result("stall", 24'd11, 8'd2, 1'b0, 0);
        apply_stimulus(16'd1, 1'b1);
        collect_result("post_stall", 24'd1, 8'd1, 1'b0, 0);

        // Reset midway through a vector discards the partial sum.
        apply_stimulus(16'd1000, 1'b0);
        apply_stimulus(16'd2000, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        check_output("midrst_sum", 32'(io_outs_0), 32'd0);
        check_output("midrst_count", 32'(io_out_count), 32'd0);
        check_output("midrst_in_ready", 32'(io_in_ready), 32'd1);
        @(negedge clock);
        reset_n = 1'b1;
        tick();
        apply_stimulus(16'd7, 1'b0);
        apply_stimulus(16'd8, 1'b1);
        collect_result("midrst", 24'd15, 8'd2, 1'b0, 0);

        // Back-to-back: next term offered during the result handshake.
        apply_stimulus(16'd10, 1'b0);
        apply_stimulus(16'd20, 1'b1);
        io_out_ready = 1'b1;
        io_inputs_0  = 16'd5;
        io_in_valid  = 1'b1;
        tick();
        io_out_ready = 1'b0;
        check_output("b2b_in_ready", 32'(io_in_ready), 32'd1);
        check_output("b2b_cleared", 32'(io_out_count), 32'd0);
        tick();
        io_in_valid = 1'b0;
        check_output("b2b_first_count", 32'(io_out_count), 32'd1);
        check_output("b2b_first_sum", 32'(io_outs_0), 32'd5);
        apply_stimulus(16'd6, 1'b1);
        collect_result("b2b", 24'd11, 8'd2, 1'b0, 0);

        // Randomized vectors with idle gaps (stray last while not valid) and output stalls.
        for (int v = 0; v < 20; v++) begin
            n   = int'($urandom_range(1, 6));
            sum = 0;
            for (int j = 0; j < n; j++) begin
                repeat ($urandom_range(0, 2)) begin
                    io_in_valid = 1'b0;
                    io_in_last  = 1'($urandom_range(0, 1));
                    tick();
                end
                t   = 16'($urandom_range(0, 65535));
                sum += longint'(t);
                apply_stimulus(t, j == n - 1);
            end
            model_vec(sum, n, r, c, o);
            collect_result($sformatf("rand%0d", v), r, c, o, int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
